// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the MIPS execute stage
package cpu_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MFHI = 4'd12;
  localparam logic [3:0] ALU_MFLO = 4'd13;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_MEMWB = 2'd1;
  localparam logic [1:0] FWD_EXMEM = 2'd2;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_RUN  = 2'd1,
    MULT_DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/ex_stage_mult_unit.sv
// rtl/ex_stage_mult_unit.sv - iterative signed shift-add multiplier owning HI/LO
import cpu_pkg::*;

module mult_unit #(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             idle,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(MULT_CYCLES + 1);

  mult_state_t          state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 neg;
  logic [CNT_W-1:0]     count;
  logic                 accept;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;

  assign accept = (state == MULT_IDLE) && start && !flush && !reset;
  assign stall  = accept || (state == MULT_RUN);
  assign idle   = (state == MULT_IDLE);
  assign abs_a  = op_a[WIDTH-1] ? -op_a : op_a;
  assign abs_b  = op_b[WIDTH-1] ? -op_b : op_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MULT_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        MULT_IDLE: begin
          if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, abs_a};
            mplier <= abs_b;
            neg    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            acc    <= '0;
            count  <= '0;
            state  <= MULT_RUN;
          end
        end
        MULT_RUN: begin
          if (flush) begin
            state <= MULT_IDLE;
          end else begin
            // Magnitudes only; the sign is applied once in DONE.
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (count == CNT_W'(MULT_CYCLES - 1)) state <= MULT_DONE;
          end
        end
        MULT_DONE: begin
          state <= MULT_IDLE;
          if (!flush) {hi, lo} <= neg ? -acc : acc;
        end
        default: state <= MULT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: forwarding muxes, ALU, multiplier and EX/MEM register
import cpu_pkg::*;

module ex_stage #(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_EX_Valid,
  input  logic [WIDTH-1:0] ID_EX_ReadData1,
  input  logic [WIDTH-1:0] ID_EX_ReadData2,
  input  logic [WIDTH-1:0] ID_EX_SignExtImm,
  input  logic [4:0]       ID_EX_Shamt,
  input  logic [3:0]       ID_EX_ALUOp,
  input  logic             ID_EX_ALUSrc,
  input  logic [4:0]       ID_EX_WriteReg,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_MemWrite,
  input  logic             ID_EX_MemtoReg,
  input  logic             ID_EX_IsMult,
  input  logic [1:0]       Mux_ForwardA,
  input  logic [1:0]       Mux_ForwardB,
  input  logic [WIDTH-1:0] MEM_WB_WriteData,
  input  logic             Ex_Flush,
  output logic             Stall_Ex,
  output logic             EX_MEM_Valid,
  output logic [WIDTH-1:0] EX_MEM_ALUResult,
  output logic [WIDTH-1:0] EX_MEM_StoreData,
  output logic [4:0]       EX_MEM_WriteReg,
  output logic             EX_MEM_RegWrite,
  output logic             EX_MEM_MemRead,
  output logic             EX_MEM_MemWrite,
  output logic             EX_MEM_MemtoReg
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             mult_idle;
  logic             bubble;

  always_comb begin
    case (Mux_ForwardA)
      FWD_MEMWB: op_a = MEM_WB_WriteData;
      FWD_EXMEM: op_a = EX_MEM_ALUResult;
      default:   op_a = ID_EX_ReadData1;
    endcase
    case (Mux_ForwardB)
      FWD_MEMWB: fwd_b = MEM_WB_WriteData;
      FWD_EXMEM: fwd_b = EX_MEM_ALUResult;
      default:   fwd_b = ID_EX_ReadData2;
    endcase
  end

  assign op_b = ID_EX_ALUSrc ? ID_EX_SignExtImm : fwd_b;

  always_comb begin
    alu_result = '0;
    case (ID_EX_ALUOp)
      ALU_ADD:  alu_result = op_a + op_b;
      ALU_SUB:  alu_result = op_a - op_b;
      ALU_AND:  alu_result = op_a & op_b;
      ALU_OR:   alu_result = op_a | op_b;
      ALU_XOR:  alu_result = op_a ^ op_b;
      ALU_NOR:  alu_result = ~(op_a | op_b);
      ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_result = {{(WIDTH-1){1'b0}}, op_a < op_b};
      ALU_SLL:  alu_result = fwd_b << ID_EX_Shamt;
      ALU_SRL:  alu_result = fwd_b >> ID_EX_Shamt;
      ALU_SRA:  alu_result = $signed(fwd_b) >>> ID_EX_Shamt;
      ALU_LUI:  alu_result = {op_b[15:0], {(WIDTH-16){1'b0}}};
      ALU_MFHI: alu_result = hi;
      ALU_MFLO: alu_result = lo;
      default:  alu_result = '0;
    endcase
  end

  mult_unit #(.WIDTH(WIDTH), .MULT_CYCLES(MULT_CYCLES)) u_mult (
    .clk   (clk),
    .reset (reset),
    .start (ID_EX_Valid && ID_EX_IsMult),
    .flush (Ex_Flush),
    .op_a  (op_a),
    .op_b  (op_b),
    .stall (Stall_Ex),
    .idle  (mult_idle),
    .hi    (hi),
    .lo    (lo)
  );

  // MULT itself never writes the GPR file, so it always leaves a bubble.
  assign bubble = Ex_Flush || !ID_EX_Valid || Stall_Ex || !mult_idle || ID_EX_IsMult;

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      EX_MEM_Valid     <= 1'b0;
      EX_MEM_ALUResult <= '0;
      EX_MEM_StoreData <= '0;
      EX_MEM_WriteReg  <= '0;
      EX_MEM_RegWrite  <= 1'b0;
      EX_MEM_MemRead   <= 1'b0;
      EX_MEM_MemWrite  <= 1'b0;
      EX_MEM_MemtoReg  <= 1'b0;
    end else begin
      EX_MEM_Valid     <= 1'b1;
      EX_MEM_ALUResult <= alu_result;
      EX_MEM_StoreData <= fwd_b;
      EX_MEM_WriteReg  <= ID_EX_WriteReg;
      EX_MEM_RegWrite  <= ID_EX_RegWrite;
      EX_MEM_MemRead   <= ID_EX_MemRead;
      EX_MEM_MemWrite  <= ID_EX_MemWrite;
      EX_MEM_MemtoReg  <= ID_EX_MemtoReg;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage
module tb_ex_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ID_EX_Valid;
  logic [31:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm;
  logic [4:0]  ID_EX_Shamt;
  logic [3:0]  ID_EX_ALUOp;
  logic        ID_EX_ALUSrc;
  logic [4:0]  ID_EX_WriteReg;
  logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_IsMult;
  logic [1:0]  Mux_ForwardA, Mux_ForwardB;
  logic [31:0] MEM_WB_WriteData;
  logic        Ex_Flush;
  logic        Stall_Ex;
  logic        EX_MEM_Valid;
  logic [31:0] EX_MEM_ALUResult, EX_MEM_StoreData;
  logic [4:0]  EX_MEM_WriteReg;
  logic        EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemtoReg;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] store;
    logic [4:0]  wreg;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_got, mon_want;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .ID_EX_Valid(ID_EX_Valid), .ID_EX_ReadData1(ID_EX_ReadData1),
    .ID_EX_ReadData2(ID_EX_ReadData2), .ID_EX_SignExtImm(ID_EX_SignExtImm),
    .ID_EX_Shamt(ID_EX_Shamt), .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_ALUSrc(ID_EX_ALUSrc),
    .ID_EX_WriteReg(ID_EX_WriteReg), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
    .ID_EX_MemtoReg(ID_EX_MemtoReg), .ID_EX_IsMult(ID_EX_IsMult),
    .Mux_ForwardA(Mux_ForwardA), .Mux_ForwardB(Mux_ForwardB),
    .MEM_WB_WriteData(MEM_WB_WriteData), .Ex_Flush(Ex_Flush), .Stall_Ex(Stall_Ex),
    .EX_MEM_Valid(EX_MEM_Valid), .EX_MEM_ALUResult(EX_MEM_ALUResult),
    .EX_MEM_StoreData(EX_MEM_StoreData), .EX_MEM_WriteReg(EX_MEM_WriteReg),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemRead(EX_MEM_MemRead),
    .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_MemtoReg(EX_MEM_MemtoReg)
  );

  // Monitor: every valid EX/MEM entry must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && EX_MEM_Valid) begin
      mon_got = {EX_MEM_ALUResult, EX_MEM_StoreData, EX_MEM_WriteReg,
                 EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemtoReg};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid got %h want no valid entry", mon_got);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          errors++;
          $display("FAIL exmem_entry got %h want %h", mon_got, mon_want);
        end
      end
    end
  end

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ID_EX_Valid = 0; ID_EX_ReadData1 = 0; ID_EX_ReadData2 = 0; ID_EX_SignExtImm = 0;
    ID_EX_Shamt = 0; ID_EX_ALUOp = 0; ID_EX_ALUSrc = 0; ID_EX_WriteReg = 0;
    ID_EX_RegWrite = 0; ID_EX_MemRead = 0; ID_EX_MemWrite = 0; ID_EX_MemtoReg = 0;
    ID_EX_IsMult = 0; Mux_ForwardA = 0; Mux_ForwardB = 0; Ex_Flush = 0;
  endtask

  task automatic alu_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] imm, input logic src, input logic [4:0] shamt,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [4:0] wreg,
                        input logic rw, input logic mw,
                        input logic [31:0] exp_alu, input logic [31:0] exp_store);
    exp_t e;
    clear_in();
    ID_EX_Valid = 1; ID_EX_ALUOp = op; ID_EX_ReadData1 = rs; ID_EX_ReadData2 = rt;
    ID_EX_SignExtImm = imm; ID_EX_ALUSrc = src; ID_EX_Shamt = shamt;
    Mux_ForwardA = fa; Mux_ForwardB = fb; ID_EX_WriteReg = wreg;
    ID_EX_RegWrite = rw; ID_EX_MemWrite = mw;
    e = {exp_alu, exp_store, wreg, rw, 1'b0, mw, 1'b0};
    exp_q.push_back(e);
    tick();
  endtask

  task automatic start_mult(input logic [31:0] a, input logic [31:0] b);
    clear_in();
    ID_EX_Valid = 1; ID_EX_IsMult = 1; ID_EX_ReadData1 = a; ID_EX_ReadData2 = b;
  endtask

  initial begin
    reset = 1;
    MEM_WB_WriteData = 0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    check("reset_exmem", {EX_MEM_Valid, EX_MEM_ALUResult, EX_MEM_StoreData, EX_MEM_WriteReg,
          EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemtoReg}, 80'd0);
    check("reset_stall", Stall_Ex, 0);

    // Flush mid-multiply at RUN count 10.
    start_mult(32'h0001_0000, 32'h0001_0000);
    #1;
    check("flush_accept_stall", Stall_Ex, 1);
    tick();
    repeat (10) tick();
    check("flush_run_stall", Stall_Ex, 1);
    clear_in();
    Ex_Flush = 1;
    tick();
    Ex_Flush = 0;
    #1;
    check("flush_stall_low", Stall_Ex, 0);
    alu_op(ALU_MFHI, 0, 0, 0, 0, 0, 0, 0, 5'd8, 1, 0, 32'h0, 32'h0);
    alu_op(ALU_MFLO, 0, 0, 0, 0, 0, 0, 0, 5'd9, 1, 0, 32'h0, 32'h0);

    // Forwarding priority.
    MEM_WB_WriteData = 32'd9;
    alu_op(ALU_ADD, 32'd3, 0, 32'd4, 1, 0, 2'd0, 2'd0, 5'd2, 1, 0, 32'd7, 32'd0);
    alu_op(ALU_ADD, 32'd5, 0, 32'd1, 1, 0, 2'd2, 2'd0, 5'd3, 1, 0, 32'd8, 32'd0);
    alu_op(ALU_ADD, 32'd5, 0, 32'd1, 1, 0, 2'd1, 2'd0, 5'd3, 1, 0, 32'd10, 32'd0);
    alu_op(ALU_ADD, 32'd5, 0, 32'd1, 1, 0, 2'd3, 2'd0, 5'd3, 1, 0, 32'd6, 32'd0);

    // Store data taken from the forwarded rt path.
    MEM_WB_WriteData = 32'hDEAD_BEEF;
    alu_op(ALU_ADD, 32'h100, 0, 32'd4, 1, 0, 2'd0, 2'd1, 5'd0, 0, 1, 32'h104, 32'hDEAD_BEEF);

    // ALU corners.
    alu_op(ALU_SLT,  32'h8000_0000, 32'd1, 0, 0, 0, 0, 0, 5'd4, 1, 0, 32'd1, 32'd1);
    alu_op(ALU_SLTU, 32'h8000_0000, 32'd1, 0, 0, 0, 0, 0, 5'd4, 1, 0, 32'd0, 32'd1);
    alu_op(ALU_SRA,  0, 32'h8000_0000, 0, 0, 5'd31, 0, 0, 5'd5, 1, 0, 32'hFFFF_FFFF, 32'h8000_0000);
    alu_op(ALU_ADD,  32'h7FFF_FFFF, 32'd1, 0, 0, 0, 0, 0, 5'd6, 1, 0, 32'h8000_0000, 32'd1);
    alu_op(ALU_LUI,  0, 0, 32'h0000_1234, 1, 0, 0, 0, 5'd7, 1, 0, 32'h1234_0000, 32'd0);
    alu_op(4'd15,    32'd5, 32'd3, 0, 0, 0, 0, 0, 5'd7, 1, 0, 32'd0, 32'd3);
    clear_in();
    tick();

    // Signed multiply -3 * 7.
    start_mult(32'hFFFF_FFFD, 32'd7);
    #1;
    n = 0;
    while (Stall_Ex && n < 100) begin
      n++;
      tick();
    end
    check("mult_stall_cycles", n, 33);
    tick();
    alu_op(ALU_MFLO, 0, 0, 0, 0, 0, 0, 0, 5'd8, 1, 0, 32'hFFFF_FFEB, 32'd0);
    alu_op(ALU_MFHI, 0, 0, 0, 0, 0, 0, 0, 5'd9, 1, 0, 32'hFFFF_FFFF, 32'd0);

    // Reset during RUN at count 5.
    start_mult(32'd5, 32'd5);
    tick();
    repeat (5) tick();
    clear_in();
    reset = 1;
    tick();
    reset = 0;
    #1;
    check("rst_run_exmem", {EX_MEM_Valid, EX_MEM_ALUResult, EX_MEM_StoreData, EX_MEM_WriteReg,
          EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemtoReg}, 80'd0);
    check("rst_run_stall", Stall_Ex, 0);
    alu_op(ALU_MFHI, 0, 0, 0, 0, 0, 0, 0, 5'd8, 1, 0, 32'h0, 32'd0);
    alu_op(ALU_MFLO, 0, 0, 0, 0, 0, 0, 0, 5'd9, 1, 0, 32'h0, 32'd0);

    clear_in();
    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; consumes the ID/EX register outputs and the forwarding-unit selects, then drives the EX/MEM pipeline register.
- Contains:
  - forwarded-operand muxes
  - ALU
  - iterative signed 32x32 multiplier writing HI/LO
  - EX/MEM register with flush/bubble insertion
- Raises Stall_Ex to freeze PC, IF/ID and ID/EX while a MULT is running.

Parameters:
- WIDTH, 32, datapath width.
- MULT_CYCLES, 32, multiplier iteration count; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ID_EX_Valid  in  1  ID/EX holds a real instruction.
- ID_EX_ReadData1  in  WIDTH  rs value from the register file.
- ID_EX_ReadData2  in  WIDTH  rt value from the register file.
- ID_EX_SignExtImm  in  WIDTH  sign-extended immediate.
- ID_EX_Shamt  in  5  shift amount.
- ID_EX_ALUOp  in  4  ALU operation code (package constants).
- ID_EX_ALUSrc  in  1  1 selects the immediate as operand B.
- ID_EX_WriteReg  in  5  destination register (RegDst already resolved).
- ID_EX_RegWrite  in  1  control bit.
- ID_EX_MemRead  in  1  control bit.
- ID_EX_MemWrite  in  1  control bit.
- ID_EX_MemtoReg  in  1  control bit.
- ID_EX_IsMult  in  1  instruction is MULT.
- Mux_ForwardA  in  2  0 = register file, 1 = MEM/WB, 2 = EX/MEM, 3 treated as 0.
- Mux_ForwardB  in  2  same encoding as Mux_ForwardA.
- MEM_WB_WriteData  in  WIDTH  writeback value for forwarding.
- Ex_Flush  in  1  squash the EX instruction (branch mispredict).
- Stall_Ex  out  1  freeze upstream stages.
- EX_MEM_Valid  out  1  registered.
- EX_MEM_ALUResult  out  WIDTH  registered.
- EX_MEM_StoreData  out  WIDTH  registered.
- EX_MEM_WriteReg  out  5  registered.
- EX_MEM_RegWrite  out  1  registered.
- EX_MEM_MemRead  out  1  registered.
- EX_MEM_MemWrite  out  1  registered.
- EX_MEM_MemtoReg  out  1  registered.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- On reset:
  - all EX_MEM_* outputs 0.
  - HI = LO = 0.
  - multiplier state IDLE.
  - Stall_Ex 0 from the first cycle after reset.
- Forwarding:
  - opA = ReadData1, MEM_WB_WriteData, or EX_MEM_ALUResult, per Mux_ForwardA.
  - fwdB is selected the same way per Mux_ForwardB.
  - opB = ALUSrc ? SignExtImm : fwdB.
  - StoreData = fwdB (pre-ALUSrc).
- ALU, combinational; all results wrap modulo 2^WIDTH and no overflow trap:
  - ADD, SUB, AND, OR, XOR, NOR.
  - SLT (signed) and SLTU: result 0 or 1.
  - SLL, SRL, SRA: shift fwdB by Shamt.
  - LUI: {opB[15:0],16'b0}.
  - MFHI, MFLO: output HI or LO.
  - Undefined codes yield 0.
- EX/MEM register, updated every cycle when not in reset:
  - Bubble = Valid and all control bits 0, ALUResult 0, StoreData 0, WriteReg 0.
  - Load a bubble when any of these hold:
    - Ex_Flush.
    - !ID_EX_Valid.
    - Stall_Ex.
    - state != IDLE.
    - the instruction is MULT (MULT never writes the GPR file).
  - Otherwise load the ALU result, StoreData and control bits with Valid = 1. Latency is 1 cycle.
- Multiplier FSM: IDLE, RUN, DONE.
  - Accept condition: IDLE and ID_EX_Valid and ID_EX_IsMult and !Ex_Flush.
    - Latch |opA|, |opB| and the result sign (opA[31]^opB[31]).
    - Clear the 64-bit accumulator; set count = 0; go to RUN.
  - RUN, once per cycle:
    - Shift-add one multiplier bit; count++.
    - After MULT_CYCLES iterations go to DONE.
  - DONE:
    - Negate the product if the sign bit is set.
    - Write {HI,LO} at the clock edge ending DONE, then go to IDLE.
  - Stall_Ex = (IDLE && accept) || RUN. It is high for exactly 1 + MULT_CYCLES = 33 consecutive cycles and low in DONE, so ID/EX advances at the end of DONE.
  - An instruction entering EX the cycle after DONE reads the new HI/LO.
- Flush mid-multiply: Ex_Flush in RUN or DONE returns to IDLE next cycle, HI/LO unchanged, Stall_Ex low from the next cycle.
- Ex_Flush and accept in the same cycle: flush wins, no accept.
- Reset mid-multiply: state IDLE, HI/LO 0.
- Forward select 3: treated as 0, no X propagation.

Decomposition:
- cpu_pkg holds:
  - ALU opcode constants (4-bit).
  - FWD_REG = 0, FWD_MEMWB = 1, FWD_EXMEM = 2.
  - multiplier state encoding.
  - WIDTH default.
- One natural sub-module, mult_unit: the FSM, accumulator, HI/LO and a busy/stall output. The ex_stage top contains the muxes, ALU and EX/MEM register.

Test Plan:
- Forwarding priority: ReadData1 = 5, EX_MEM_ALUResult = 7 (previous ADD), MEM_WB_WriteData = 9, ADD with opB = 1.
  - Mux_ForwardA = 2 -> EX_MEM_ALUResult = 8.
  - Mux_ForwardA = 1 -> 10.
  - Mux_ForwardA = 3 -> 6.
- Store data path: SW with ALUSrc = 1, imm = 4, fwdB via Mux_ForwardB = 1 (MEM_WB = 0xDEADBEEF), base = 0x100 -> EX_MEM_ALUResult = 0x104, StoreData = 0xDEADBEEF, MemWrite = 1, RegWrite = 0.
- Signed multiply: MULT -3 * 7 -> Stall_Ex high exactly 33 cycles and EX/MEM bubbles throughout; following MFLO -> 0xFFFFFFEB, MFHI -> 0xFFFFFFFF.
- Flush mid-multiply: MULT 0x10000 * 0x10000 with Ex_Flush asserted at RUN count 10 -> Stall_Ex low next cycle, HI/LO keep prior values (0 after reset).
- ALU corner cases:
  - SLT 0x80000000 vs 1 -> 1.
  - SLTU same operands -> 0.
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF.
  - ADD 0x7FFFFFFF + 1 -> 0x80000000, no trap.
- Reset during RUN: reset asserted at count 5 -> next cycle all EX_MEM_* 0, Stall_Ex 0, MFHI/MFLO return 0.
